// File: rtl/keypad4x4_scan_if.sv
// Keypad scanner bus: matrix row/column pins, clear request and key/digit outputs.
interface keypad4x4_scan_if;
   logic [3:0]  i_col;
   logic        i_clear;
   logic [3:0]  o_row;
   logic        o_key_valid;
   logic [3:0]  o_key_code;
   logic [31:0] o_data;

   // Environment side: drives the columns and clear, observes the scanner
   modport master (
      output i_col,
      output i_clear,
      input  o_row,
      input  o_key_valid,
      input  o_key_code,
      input  o_data
   );

   // Scanner side
   modport slave (
      input  i_col,
      input  i_clear,
      output o_row,
      output o_key_valid,
      output o_key_code,
      output o_data
   );
endinterface

// File: rtl/keypad4x4_scan.sv
// 4x4 matrix keypad scanner: active-low row drive, debounced press/release,
// hex encoding and a 32-bit right-aligned digit shift register.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad4x4_scan #(
   parameter int unsigned SCAN_DIV       = 10000,
   parameter int unsigned DEBOUNCE_TICKS = 20,
   parameter int unsigned REPEAT_TICKS   = 200
) (
   input logic             clk,
   input logic             reset,
   keypad4x4_scan_if.slave bus
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   // The SCAN sample that triggered DEBOUNCE counts as the first stable sample
   localparam logic [DEB_W-1:0] DEB_FIRE = DEB_W'((DEBOUNCE_TICKS > 1) ? DEBOUNCE_TICKS - 2 : 0);
   localparam logic [DEB_W-1:0] REL_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        col_meta_q, col_meta_d;
   logic [3:0]        col_s_q, col_s_d;
   logic [3:0]        row_q, row_d;
   logic [3:0]        lat_col_q, lat_col_d;
   logic [1:0]        lat_row_q, lat_row_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [DEB_W-1:0]  rel_cnt_q, rel_cnt_d;
   logic              valid_q, valid_d;
   logic [3:0]        code_q, code_d;
   logic [31:0]       data_q, data_d;

   logic              tick_c;
   logic              one_low_c;
   logic [1:0]        row_idx_c;
   logic [1:0]        lat_cidx_c;
   logic [3:0]        key_code_c;
   logic              event_c;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
   logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
`else
   logic [31:0]       unused_repeat_ticks;
   assign unused_repeat_ticks = 32'(REPEAT_TICKS);
`endif

   // Row encoding of the active (low) row and column decode of the latched pattern
   always_comb begin
      row_idx_c  = 2'd0;
      one_low_c  = 1'b0;
      lat_cidx_c = 2'd0;
      case (row_q)
         4'b1110: row_idx_c = 2'd0;
         4'b1101: row_idx_c = 2'd1;
         4'b1011: row_idx_c = 2'd2;
         4'b0111: row_idx_c = 2'd3;
         default: row_idx_c = 2'd0;
      endcase
      case (col_s_q)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low_c = 1'b1;
         default:                            one_low_c = 1'b0;
      endcase
      case (lat_col_q)
         4'b1110: lat_cidx_c = 2'd0;
         4'b1101: lat_cidx_c = 2'd1;
         4'b1011: lat_cidx_c = 2'd2;
         4'b0111: lat_cidx_c = 2'd3;
         default: lat_cidx_c = 2'd0;
      endcase
   end

   // Key map: r0 1 2 3 A | r1 4 5 6 B | r2 7 8 9 C | r3 E 0 F D
   always_comb begin
      key_code_c = 4'h0;
      case ({lat_row_q, lat_cidx_c})
         4'd0:  key_code_c = 4'h1;
         4'd1:  key_code_c = 4'h2;
         4'd2:  key_code_c = 4'h3;
         4'd3:  key_code_c = 4'hA;
         4'd4:  key_code_c = 4'h4;
         4'd5:  key_code_c = 4'h5;
         4'd6:  key_code_c = 4'h6;
         4'd7:  key_code_c = 4'hB;
         4'd8:  key_code_c = 4'h7;
         4'd9:  key_code_c = 4'h8;
         4'd10: key_code_c = 4'h9;
         4'd11: key_code_c = 4'hC;
         4'd12: key_code_c = 4'hE;
         4'd13: key_code_c = 4'h0;
         4'd14: key_code_c = 4'hF;
         default: key_code_c = 4'hD;
      endcase
   end

   // Prescaler, synchroniser, scan FSM and output next-state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      col_meta_d = bus.i_col;
      col_s_d    = col_meta_q;
      row_d      = row_q;
      lat_col_d  = lat_col_q;
      lat_row_d  = lat_row_q;
      deb_cnt_d  = deb_cnt_q;
      rel_cnt_d  = rel_cnt_q;
      valid_d    = 1'b0;
      code_d     = code_q;
      data_d     = data_q;
      event_c    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_d  = rep_cnt_q;
`endif

      tick_c = (cnt_q == DIV_LAST);
      cnt_d  = tick_c ? '0 : cnt_q + DIV_W'(1);

      if (tick_c) begin
         case (state_q)
            SCAN: begin
               if (one_low_c) begin
                  lat_col_d = col_s_q;
                  lat_row_d = row_idx_c;
                  deb_cnt_d = '0;
                  state_d   = DEBOUNCE;
               end else begin
                  row_d = {row_q[2:0], row_q[3]};
               end
            end
            DEBOUNCE: begin
               if (col_s_q == lat_col_q) begin
                  if (deb_cnt_q == DEB_FIRE) begin
                     event_c   = 1'b1;
                     rel_cnt_d = '0;
                     state_d   = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rep_cnt_d = '0;
`endif
                  end else begin
                     deb_cnt_d = deb_cnt_q + DEB_W'(1);
                  end
               end else begin
                  state_d = SCAN;
               end
            end
            HELD: begin
               if (col_s_q == 4'b1111) begin
                  if (rel_cnt_q == REL_LAST) begin
                     rel_cnt_d = '0;
                     row_d     = {row_q[2:0], row_q[3]};
                     state_d   = SCAN;
                  end else begin
                     rel_cnt_d = rel_cnt_q + DEB_W'(1);
                  end
               end else begin
                  rel_cnt_d = '0;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               if (col_s_q == lat_col_q) begin
                  if (rep_cnt_q == REP_LAST) begin
                     event_c   = 1'b1;
                     rep_cnt_d = '0;
                  end else begin
                     rep_cnt_d = rep_cnt_q + REP_W'(1);
                  end
               end
`endif
            end
            default: state_d = SCAN;
         endcase
      end

      if (event_c) begin
         valid_d = 1'b1;
         code_d  = key_code_c;
         data_d  = {data_q[27:0], key_code_c};
      end
      // Clear has priority over a digit insertion in the same clk
      if (bus.i_clear) begin
         data_d = '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= SCAN;
         cnt_q      <= '0;
         col_meta_q <= 4'b1111;
         col_s_q    <= 4'b1111;
         row_q      <= 4'b1110;
         lat_col_q  <= 4'b1111;
         lat_row_q  <= 2'd0;
         deb_cnt_q  <= '0;
         rel_cnt_q  <= '0;
         valid_q    <= 1'b0;
         code_q     <= 4'h0;
         data_q     <= 32'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         col_meta_q <= col_meta_d;
         col_s_q    <= col_s_d;
         row_q      <= row_d;
         lat_col_q  <= lat_col_d;
         lat_row_q  <= lat_row_d;
         deb_cnt_q  <= deb_cnt_d;
         rel_cnt_q  <= rel_cnt_d;
         valid_q    <= valid_d;
         code_q     <= code_d;
         data_q     <= data_d;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt_q  <= rep_cnt_d;
`endif
      end
   end

   assign bus.o_row       = row_q;
   assign bus.o_key_valid = valid_q;
   assign bus.o_key_code  = code_q;
   assign bus.o_data      = data_q;

endmodule

// File: tb/tb_keypad4x4_scan.sv
// Directed bench for keypad4x4_scan with a behavioural single-key matrix model.
module tb_keypad4x4_scan;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   pulse_cnt = 0;
   int   base;

   logic       key_down;
   logic [1:0] key_r;
   logic [1:0] key_c;

   keypad4x4_scan_if bus ();

   keypad4x4_scan #(
      .SCAN_DIV       (4),
      .DEBOUNCE_TICKS (3),
      .REPEAT_TICKS   (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Matrix model: the pressed key pulls its column low only while its row is driven
   assign bus.i_col = (key_down && bus.o_row[key_r] == 1'b0) ? ~(4'b0001 << key_c) : 4'b1111;

   // Count accepted key events
   always @(negedge clk) begin
      if (bus.o_key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Returns at the first negedge after o_row becomes r
   task automatic wait_row(input logic [3:0] r, input string tag);
      int n = 0;
      while (bus.o_row == r && n < 64) begin @(negedge clk); n++; end
      while (bus.o_row != r && n < 64) begin @(negedge clk); n++; end
      check(tag, 32'(bus.o_row), 32'(r));
   endtask

   task automatic press_key(input logic [1:0] r, input logic [1:0] c);
      key_r = r;
      key_c = c;
      key_down = 1'b1;
      repeat (48) @(negedge clk);
      key_down = 1'b0;
      repeat (24) @(negedge clk);
   endtask

   logic [3:0] exp_rows [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
   logic [1:0] seq_r [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
   logic [1:0] seq_c [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      reset = 1'b1;
      key_down = 1'b0;
      key_r = 2'd0;
      key_c = 2'd0;
      bus.i_clear = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_row",   32'(bus.o_row), 32'h0000000e);
      check("rst_valid", 32'(bus.o_key_valid), 32'h0);
      check("rst_code",  32'(bus.o_key_code), 32'h0);
      check("rst_data",  bus.o_data, 32'h0);
      reset = 1'b0;

      // Idle scan: row rotates once every 4 clks
      for (int k = 0; k < 4; k++) begin
         repeat (4) @(posedge clk);
         @(negedge clk);
         check($sformatf("idle_row%0d", k), 32'(bus.o_row), 32'(exp_rows[k]));
      end
      check("idle_pulses", 32'(pulse_cnt), 32'h0);
      check("idle_data", bus.o_data, 32'h0);

      // Key 5 with exact latency, held 20 ticks
      wait_row(4'b1101, "wait_row1");
      key_r = 2'd1; key_c = 2'd1; key_down = 1'b1;
      base = pulse_cnt;
      repeat (11) @(posedge clk);
      @(negedge clk);
      check("k5_early", 32'(bus.o_key_valid), 32'h0);
      @(negedge clk);
      check("k5_valid", 32'(bus.o_key_valid), 32'h1);
      check("k5_code",  32'(bus.o_key_code), 32'h5);
      check("k5_data",  bus.o_data, 32'h5);
      @(negedge clk);
      check("k5_pulse_len", 32'(bus.o_key_valid), 32'h0);
      repeat (68) @(negedge clk);
      key_down = 1'b0;
      repeat (24) @(negedge clk);
      check("k5_pulses", 32'(pulse_cnt - base), 32'h1);

      // Nine keys in order; first digit shifts out
      bus.i_clear = 1'b1;
      @(negedge clk);
      bus.i_clear = 1'b0;
      check("clear_data", bus.o_data, 32'h0);
      base = pulse_cnt;
      for (int i = 0; i < 9; i++) press_key(seq_r[i], seq_c[i]);
      check("seq_pulses", 32'(pulse_cnt - base), 32'd9);
      check("seq_code", 32'(bus.o_key_code), 32'h7);
      check("seq_data", bus.o_data, 32'h23A456B7);

      // Key D bouncing on alternate ticks, then stable
      key_r = 2'd3; key_c = 2'd3;
      base = pulse_cnt;
      for (int i = 0; i < 16; i++) begin
         key_down = (i % 2 == 0);
         repeat (4) @(negedge clk);
      end
      key_down = 1'b0;
      repeat (8) @(negedge clk);
      check("bounce_no_pulse", 32'(pulse_cnt - base), 32'h0);
      key_down = 1'b1;
      repeat (48) @(negedge clk);
      key_down = 1'b0;
      repeat (24) @(negedge clk);
      check("kd_pulses", 32'(pulse_cnt - base), 32'h1);
      check("kd_code", 32'(bus.o_key_code), 32'hd);
      check("kd_data", bus.o_data, 32'h3A456B7D);

      // Clear coinciding with a key-9 event
      wait_row(4'b1011, "wait_row2");
      key_r = 2'd2; key_c = 2'd2; key_down = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      bus.i_clear = 1'b1;
      @(negedge clk);
      bus.i_clear = 1'b0;
      key_down = 1'b0;
      check("clr9_valid", 32'(bus.o_key_valid), 32'h1);
      check("clr9_code", 32'(bus.o_key_code), 32'h9);
      check("clr9_data", bus.o_data, 32'h0);
      repeat (24) @(negedge clk);
      check("clr9_data_after", bus.o_data, 32'h0);

      // Key 1 then hold key 0 for 13+ ticks
      press_key(2'd0, 2'd0);
      check("pre0_data", bus.o_data, 32'h1);
      wait_row(4'b0111, "wait_row3");
      key_r = 2'd3; key_c = 2'd1; key_down = 1'b1;
      base = pulse_cnt;
      repeat (56) @(negedge clk);
      key_down = 1'b0;
      repeat (24) @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
      check("hold0_pulses", 32'(pulse_cnt - base), 32'd3);
      check("hold0_data", bus.o_data, 32'h1000);
`else
      check("hold0_pulses", 32'(pulse_cnt - base), 32'd1);
      check("hold0_data", bus.o_data, 32'h10);
`endif
      check("hold0_code", 32'(bus.o_key_code), 32'h0);

      // Reset while debouncing key 1
      wait_row(4'b1110, "wait_row0");
      base = pulse_cnt;
      key_r = 2'd0; key_c = 2'd0; key_down = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_row", 32'(bus.o_row), 32'h0000000e);
      check("rst_mid_valid", 32'(bus.o_key_valid), 32'h0);
      check("rst_mid_data", bus.o_data, 32'h0);
      key_down = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (80) @(negedge clk);
      check("rst_mid_pulses", 32'(pulse_cnt - base), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
